// File: rtl/ps2_command_tx_pkg.sv
// Shared PS/2 definitions: controller states, error codes, default timing
// constants and small helpers used by both the transmit and receive paths.
package ps2_command_tx_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    REQ       = 3'd2,
    XFER      = 3'd3,
    ACK       = 3'd4,
    WAIT_IDLE = 3'd5,
    DONE      = 3'd6,
    ERR       = 3'd7
  } ps2_tx_state_e;

  localparam logic [1:0] ERRC_NONE           = 2'b00;
  localparam logic [1:0] ERRC_START_TIMEOUT  = 2'b01;
  localparam logic [1:0] ERRC_PACKET_TIMEOUT = 2'b10;
  localparam logic [1:0] ERRC_NO_ACK         = 2'b11;

  // Defaults assume a 50 MHz system clock.
  localparam int DEF_CLK_INHIBIT    = 5000;    // 100 us
  localparam int DEF_START_TIMEOUT  = 750000;  // 15 ms
  localparam int DEF_PACKET_TIMEOUT = 100000;  // 2 ms

  // PS/2 frames carry odd parity over the eight data bits.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ps2_command_tx_line_sync.sv
// Two-flop synchronizers for the PS/2 clock and data pads plus a one-cycle
// strobe on each falling edge of the synchronized clock.
module ps2_line_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic ps2_clk_i,
  input  logic ps2_dat_i,
  output logic clk_sync_o,
  output logic dat_sync_o,
  output logic clk_fall_o
);

  logic [1:0] clk_ff_q;
  logic [1:0] dat_ff_q;
  logic       clk_prev_q;

  // Reset to the idle-high level so no false edge appears on release.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      clk_ff_q   <= 2'b11;
      dat_ff_q   <= 2'b11;
      clk_prev_q <= 1'b1;
    end else begin
      clk_ff_q   <= {clk_ff_q[0], ps2_clk_i};
      dat_ff_q   <= {dat_ff_q[0], ps2_dat_i};
      clk_prev_q <= clk_ff_q[1];
    end
  end

  assign clk_sync_o = clk_ff_q[1];
  assign dat_sync_o = dat_ff_q[1];
  assign clk_fall_o = clk_prev_q & ~clk_ff_q[1];

endmodule

// File: rtl/ps2_command_tx.sv
// Host-to-device PS/2 command transmitter: inhibits the clock, issues the
// request-to-send, shifts out one byte with odd parity and checks the ACK.
module ps2_command_tx
  import ps2_command_tx_pkg::*;
#(
  parameter int CLK_INHIBIT    = DEF_CLK_INHIBIT,
  parameter int START_TIMEOUT  = DEF_START_TIMEOUT,
  parameter int PACKET_TIMEOUT = DEF_PACKET_TIMEOUT
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] cmd_data,
  input  logic       cmd_send,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       busy,
  output logic       cmd_done,
  output logic       cmd_error,
  output logic [1:0] error_code
);

  localparam int MAX_CNT = max3(CLK_INHIBIT, START_TIMEOUT, PACKET_TIMEOUT);
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  localparam logic [CNT_W-1:0] INH_LAST   = CNT_W'(CLK_INHIBIT - 1);
  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] PKT_LAST   = CNT_W'(PACKET_TIMEOUT - 1);

  ps2_tx_state_e    state_q, state_d;
  logic [7:0]       data_q, data_d;
  logic [3:0]       edge_q, edge_d;
  logic [CNT_W-1:0] tmr_q, tmr_d;
  logic [CNT_W-1:0] pkt_q, pkt_d;
  logic             dat_oe_q, dat_oe_d;
  logic [1:0]       err_q, err_d;

  logic clk_sync, dat_sync, clk_fall;
  logic start_to, pkt_to, no_ack;

  ps2_line_sync u_line_sync (
    .clk_i      (CLOCK_50),
    .rst_i      (reset),
    .ps2_clk_i  (ps2_clk_in),
    .ps2_dat_i  (ps2_dat_in),
    .clk_sync_o (clk_sync),
    .dat_sync_o (dat_sync),
    .clk_fall_o (clk_fall)
  );

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    edge_d   = edge_q;
    tmr_d    = tmr_q;
    pkt_d    = pkt_q;
    dat_oe_d = dat_oe_q;
    err_d    = err_q;
    start_to = 1'b0;
    pkt_to   = 1'b0;
    no_ack   = 1'b0;

    // Packet timer runs from the first device edge until the frame completes.
    if (state_q == XFER || state_q == ACK || state_q == WAIT_IDLE) begin
      pkt_d  = pkt_q + 1'b1;
      pkt_to = (pkt_q == PKT_LAST);
    end

    unique case (state_q)
      IDLE: begin
        if (cmd_send) begin
          data_d   = cmd_data;
          err_d    = ERRC_NONE;
          tmr_d    = '0;
          edge_d   = '0;
          dat_oe_d = 1'b0;
          state_d  = INHIBIT;
        end
      end

      INHIBIT: begin
        if (tmr_q == INH_LAST) begin
          tmr_d    = '0;
          dat_oe_d = 1'b1;
          state_d  = REQ;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end

      REQ: begin
        if (clk_fall) begin
          edge_d   = 4'd1;
          pkt_d    = CNT_W'(1);
          dat_oe_d = ~data_q[0];
          state_d  = XFER;
        end else if (tmr_q == START_LAST) begin
          start_to = 1'b1;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end

      // edge_q holds the count already seen, so edge n drives data bit n-1 = edge_q.
      XFER: begin
        if (clk_fall) begin
          edge_d = edge_q + 4'd1;
          if (edge_q <= 4'd7) begin
            dat_oe_d = ~data_q[edge_q[2:0]];
          end else if (edge_q == 4'd8) begin
            dat_oe_d = ~odd_parity(data_q);
          end else begin
            dat_oe_d = 1'b0;
            state_d  = ACK;
          end
        end
      end

      ACK: begin
        if (clk_fall) begin
          edge_d = 4'd11;
          if (dat_sync) begin
            no_ack = 1'b1;
          end else begin
            state_d = WAIT_IDLE;
          end
        end
      end

      WAIT_IDLE: begin
        if (clk_sync && dat_sync) begin
          dat_oe_d = 1'b0;
          state_d  = DONE;
        end
      end

      DONE, ERR: begin
        dat_oe_d = 1'b0;
        edge_d   = '0;
        state_d  = IDLE;
      end

      default: state_d = IDLE;
    endcase

    // Abort priority: start timeout, then packet timeout, then missing ACK.
    if (start_to || pkt_to || no_ack) begin
      dat_oe_d = 1'b0;
      state_d  = ERR;
      if (start_to)    err_d = ERRC_START_TIMEOUT;
      else if (pkt_to) err_d = ERRC_PACKET_TIMEOUT;
      else             err_d = ERRC_NO_ACK;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      data_q   <= '0;
      edge_q   <= '0;
      tmr_q    <= '0;
      pkt_q    <= '0;
      dat_oe_q <= 1'b0;
      err_q    <= ERRC_NONE;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      edge_q   <= edge_d;
      tmr_q    <= tmr_d;
      pkt_q    <= pkt_d;
      dat_oe_q <= dat_oe_d;
      err_q    <= err_d;
    end
  end

  // Line enables decode from reset-cleared registers, so reset frees the bus at once.
  assign ps2_clk_oe = (state_q == INHIBIT);
  assign ps2_dat_oe = dat_oe_q;
  assign busy       = (state_q != IDLE) && (state_q != DONE) && (state_q != ERR);
  assign cmd_done   = (state_q == DONE);
  assign cmd_error  = (state_q == ERR);
  assign error_code = err_q;

endmodule
